// File: rtl/ex_stage.sv
// ex_stage: execute stage of an RV32 pipeline.
//
// Resolves operand forwarding, runs a single-cycle ALU and registers the
// result into the EX/MEM boundary. Optional iterative shift-add multiplier
// (low 32 bits of A*B), enabled by defining EX_STAGE_MUL_EN. Without the macro,
// mul_req is ignored and ex_stall is tied low.
//
// Ports:
//   clk, rst                         clock, async active-low reset
//   ctrl_in / ctrl_out               {reg_write, mem_write, mem_read, mem_op[2:0], mem_2_reg}
//   alu_src1, alu_src2               operand selects (A: rs1/pc/0/0, B: rs2/imm/4/0)
//   alu_op, alu_op_chosen            funct3-style op, SUB/SRA modifier
//   mul_req                          instruction is MUL
//   rs1, rs2, rs1_data, rs2_data     source indices and register data
//   pc, imm, rd                      operands and destination index
//   mem_fwd_*, wb_fwd_*              EX/MEM and MEM/WB forwarding sources
//   ex_stall                         hold request to ID/EX and earlier stages
//   alu_result_out, store_data_out   registered result and forwarded rs2
//   rd_out                           registered destination index
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  ctrl_in,
  input  logic [1:0]  alu_src1,
  input  logic [1:0]  alu_src2,
  input  logic [2:0]  alu_op,
  input  logic        alu_op_chosen,
  input  logic        mul_req,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [4:0]  rd,
  input  logic        mem_fwd_we,
  input  logic [4:0]  mem_fwd_rd,
  input  logic [31:0] mem_fwd_data,
  input  logic        wb_fwd_we,
  input  logic [4:0]  wb_fwd_rd,
  input  logic [31:0] wb_fwd_data,
  output logic        ex_stall,
  output logic [6:0]  ctrl_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] store_data_out,
  output logic [4:0]  rd_out
);

  logic [31:0] fwd_a, fwd_b, op_a, op_b, alu_res;
  logic [6:0]  ctrl_d;
  logic [4:0]  rd_d;
  logic [31:0] res_d, store_d;

  // Forwarding: EX/MEM beats MEM/WB; x0 is never forwarded.
  always_comb begin
    fwd_a = rs1_data;
    if (mem_fwd_we && mem_fwd_rd == rs1 && rs1 != 5'd0)     fwd_a = mem_fwd_data;
    else if (wb_fwd_we && wb_fwd_rd == rs1 && rs1 != 5'd0)  fwd_a = wb_fwd_data;
    fwd_b = rs2_data;
    if (mem_fwd_we && mem_fwd_rd == rs2 && rs2 != 5'd0)     fwd_b = mem_fwd_data;
    else if (wb_fwd_we && wb_fwd_rd == rs2 && rs2 != 5'd0)  fwd_b = wb_fwd_data;
  end

  always_comb begin
    unique case (alu_src1)
      2'b00:   op_a = fwd_a;
      2'b01:   op_a = pc;
      default: op_a = 32'd0;
    endcase
    unique case (alu_src2)
      2'b00:   op_b = fwd_b;
      2'b01:   op_b = imm;
      2'b10:   op_b = 32'd4;
      default: op_b = 32'd0;
    endcase
  end

  always_comb begin
    unique case (alu_op)
      3'b000:  alu_res = alu_op_chosen ? (op_a - op_b) : (op_a + op_b);
      3'b001:  alu_res = op_a << op_b[4:0];
      3'b010:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      3'b011:  alu_res = {31'd0, op_a < op_b};
      3'b100:  alu_res = op_a ^ op_b;
      3'b101:  alu_res = alu_op_chosen ? 32'($signed(op_a) >>> op_b[4:0]) : (op_a >> op_b[4:0]);
      3'b110:  alu_res = op_a | op_b;
      default: alu_res = op_a & op_b;
    endcase
  end

`ifdef EX_STAGE_MUL_EN
  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d, ma_q, ma_d, mb_q, mb_d;
  logic [6:0]  hctrl_q, hctrl_d;
  logic [4:0]  hrd_q, hrd_d;
  logic [31:0] hstore_q, hstore_d;
  logic        stall;

  always_comb begin
    ctrl_d   = ctrl_in;
    rd_d     = rd;
    res_d    = alu_res;
    store_d  = fwd_b;
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    hctrl_d  = hctrl_q;
    hrd_d    = hrd_q;
    hstore_d = hstore_q;
    stall    = 1'b0;
    case (state_q)
      StIdle: begin
        if (mul_req) begin
          stall    = 1'b1;
          ma_d     = op_a;
          mb_d     = op_b;
          acc_d    = 32'd0;
          cnt_d    = 5'd0;
          // Snapshot the rest of the instruction so forwarding churn can't leak in.
          hctrl_d  = ctrl_in;
          hrd_d    = rd;
          hstore_d = fwd_b;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        stall = 1'b1;
        if (mb_q[0]) acc_d = acc_q + ma_q;
        ma_d  = ma_q << 1;
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StDone;
      end
      StDone: begin
        // mul_req is still high for this instruction; deliberately ignored.
        res_d   = acc_q;
        ctrl_d  = hctrl_q;
        rd_d    = hrd_q;
        store_d = hstore_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (stall) begin
      ctrl_d  = 7'd0;
      rd_d    = 5'd0;
      res_d   = 32'd0;
      store_d = 32'd0;
    end
  end

  // Gated by rst so the stall request is low throughout reset.
  assign ex_stall = stall & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      acc_q    <= 32'd0;
      ma_q     <= 32'd0;
      mb_q     <= 32'd0;
      hctrl_q  <= 7'd0;
      hrd_q    <= 5'd0;
      hstore_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      hctrl_q  <= hctrl_d;
      hrd_q    <= hrd_d;
      hstore_q <= hstore_d;
    end
  end
`else
  logic unused_mul_req;
  assign unused_mul_req = mul_req;
  assign ex_stall = 1'b0;

  always_comb begin
    ctrl_d  = ctrl_in;
    rd_d    = rd;
    res_d   = alu_res;
    store_d = fwd_b;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_out       <= 7'd0;
      rd_out         <= 5'd0;
      alu_result_out <= 32'd0;
      store_data_out <= 32'd0;
    end else begin
      ctrl_out       <= ctrl_d;
      rd_out         <= rd_d;
      alu_result_out <= res_d;
      store_data_out <= store_d;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  logic        clk, rst;
  logic [6:0]  ctrl_in;
  logic [1:0]  alu_src1, alu_src2;
  logic [2:0]  alu_op;
  logic        alu_op_chosen, mul_req;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rs1_data, rs2_data, pc, imm;
  logic        mem_fwd_we, wb_fwd_we;
  logic [4:0]  mem_fwd_rd, wb_fwd_rd;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        ex_stall;
  logic [6:0]  ctrl_out;
  logic [31:0] alu_result_out, store_data_out;
  logic [4:0]  rd_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [6:0]  ctrl;
    logic [4:0]  rd;
    logic [31:0] store;
  } exp_t;

  exp_t sb[$];

  ex_stage dut (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_op(alu_op), .alu_op_chosen(alu_op_chosen), .mul_req(mul_req),
    .rs1(rs1), .rs2(rs2), .rs1_data(rs1_data), .rs2_data(rs2_data), .pc(pc), .imm(imm),
    .rd(rd), .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .ex_stall(ex_stall), .ctrl_out(ctrl_out), .alu_result_out(alu_result_out),
    .store_data_out(store_data_out), .rd_out(rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic defaults();
    ctrl_in = 7'h00; alu_src1 = 2'b00; alu_src2 = 2'b00; alu_op = 3'b000;
    alu_op_chosen = 1'b0; mul_req = 1'b0; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd5;
    rs1_data = 32'd0; rs2_data = 32'd0; pc = 32'd0; imm = 32'd0;
    mem_fwd_we = 1'b0; mem_fwd_rd = 5'd0; mem_fwd_data = 32'd0;
    wb_fwd_we = 1'b0; wb_fwd_rd = 5'd0; wb_fwd_data = 32'd0;
  endtask

  // Drive a register-register op and push its expected outputs.
  task automatic issue(input string tag, input logic [2:0] op, input logic ch,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res);
    alu_op = op; alu_op_chosen = ch; rs1_data = a; rs2_data = b;
    ctrl_in = 7'h4B; rd = 5'd7;
    sb.push_back('{tag, exp_res, 7'h4B, 5'd7, b});
  endtask

  // Advance one edge, then pop and compare the oldest expectation.
  task automatic retire();
    exp_t e;
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_res"}, alu_result_out, e.res);
      check({e.tag, "_ctrl"}, 32'(ctrl_out), 32'(e.ctrl));
      check({e.tag, "_rd"}, 32'(rd_out), 32'(e.rd));
      check({e.tag, "_store"}, store_data_out, e.store);
    end
  endtask

  initial begin
    defaults();
    rst = 1'b0;
    mul_req = 1'b1;
    #3;
    check("rst_stall", 32'(ex_stall), 32'd0);
    check("rst_outs", {ctrl_out, rd_out, 20'd0}, 32'd0);
    @(posedge clk); #1;
    check("rst_result", alu_result_out, 32'd0);
    check("rst_store", store_data_out, 32'd0);
    check("rst_stall_edge", 32'(ex_stall), 32'd0);
    mul_req = 1'b0;
    rst = 1'b1;

    issue("add", 3'b000, 1'b0, 32'd5, 32'd7, 32'd12);
    #1 check("add_stall", 32'(ex_stall), 32'd0);
    retire();
    issue("sub", 3'b000, 1'b1, 32'd3, 32'd5, 32'hFFFF_FFFE);   retire();
    issue("sra", 3'b101, 1'b1, 32'h8000_0000, 32'd4, 32'hF800_0000); retire();
    issue("srl", 3'b101, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000); retire();
    issue("sll", 3'b001, 1'b0, 32'h0000_0003, 32'd33, 32'h0000_0006); retire();
    issue("slt", 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1);   retire();
    issue("sltu", 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0);  retire();
    issue("xor", 3'b100, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0); retire();
    issue("or", 3'b110, 1'b0, 32'hF000_0001, 32'h0000_0100, 32'hF000_0101); retire();
    issue("and", 3'b111, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200); retire();

    // pc + 4 through the operand selects
    alu_op = 3'b000; alu_op_chosen = 1'b0; alu_src1 = 2'b01; alu_src2 = 2'b10;
    pc = 32'h0000_1000; rs2_data = 32'd9;
    sb.push_back('{"pc4", 32'h0000_1004, 7'h4B, 5'd7, 32'd9});
    retire();

    // Forwarding: A = forwarded rs1 + 0
    alu_src1 = 2'b00; alu_src2 = 2'b11; rs1 = 5'd3; rs1_data = 32'h99;
    mem_fwd_we = 1'b1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'h11;
    wb_fwd_we = 1'b1;  wb_fwd_rd = 5'd3;  wb_fwd_data = 32'h22;
    rs2 = 5'd3;
    sb.push_back('{"fwd_mem", 32'h11, 7'h4B, 5'd7, 32'h11});
    retire();
    mem_fwd_we = 1'b0;
    sb.push_back('{"fwd_wb", 32'h22, 7'h4B, 5'd7, 32'h22});
    retire();
    rs1 = 5'd0; rs2 = 5'd0; rs1_data = 32'h55; rs2_data = 32'h66;
    mem_fwd_we = 1'b1; mem_fwd_rd = 5'd0; wb_fwd_rd = 5'd0;
    sb.push_back('{"fwd_x0", 32'h55, 7'h4B, 5'd7, 32'h66});
    retire();
    defaults();

`ifdef EX_STAGE_MUL_EN
    begin
      int stall_cnt;
      exp_t e;
      stall_cnt = 0;
      rs1_data = 32'hFFFF_FFFF; rs2_data = 32'd3; mul_req = 1'b1; ctrl_in = 7'h55; rd = 5'd9;
      sb.push_back('{"mul", 32'hFFFF_FFFD, 7'h55, 5'd9, 32'd3});
      #1;
      check("mul_stall_comb", 32'(ex_stall), 32'd1);
      if (ex_stall) stall_cnt = 1;
      for (int i = 0; i < 40 && ex_stall; i++) begin
        @(posedge clk); #1;
        check("mul_bubble", {ctrl_out, rd_out, 20'd0} | alu_result_out | store_data_out, 32'd0);
        if (i == 5) begin
          mem_fwd_we = 1'b1; mem_fwd_rd = 5'd1; mem_fwd_data = 32'h1234;
          wb_fwd_we = 1'b1;  wb_fwd_rd = 5'd2;  wb_fwd_data = 32'h5678;
        end
        if (ex_stall) stall_cnt++;
      end
      check("mul_stall_cycles", 32'(stall_cnt), 32'd33);
      retire();
      defaults();
      #1 check("mul_after_stall", 32'(ex_stall), 32'd0);

      // Reset mid-multiply at counter = 10
      rs1_data = 32'd6; rs2_data = 32'd7; mul_req = 1'b1;
      repeat (11) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("midrst_stall", 32'(ex_stall), 32'd0);
      check("midrst_outs", {ctrl_out, rd_out, 20'd0} | alu_result_out | store_data_out, 32'd0);
      @(posedge clk); #1;
      mul_req = 1'b0;
      rst = 1'b1;
      issue("post_rst_add", 3'b000, 1'b0, 32'd6, 32'd7, 32'd13);
      retire();
      check("post_rst_stall", 32'(ex_stall), 32'd0);
      issue("post_rst_add2", 3'b000, 1'b0, 32'd1, 32'd2, 32'd3);
      retire();
      check("post_rst_stall2", 32'(ex_stall), 32'd0);
      e.tag = "unused";
    end
`else
    mul_req = 1'b1;
    issue("nomul_add", 3'b000, 1'b0, 32'd6, 32'd7, 32'd13);
    #1 check("nomul_stall", 32'(ex_stall), 32'd0);
    retire();
    check("nomul_stall2", 32'(ex_stall), 32'd0);
    mul_req = 1'b0;
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have a single clock and an asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-002 SHALL have rst  in  1  asynchronous reset, active-low (asserted at 0), released synchronously to clk by the system.
REQ-003 SHALL have ctrl_in  in  7  {reg_write, mem_write, mem_read, mem_op[2:0], mem_2_reg} from the ID/EX register.
REQ-004 SHALL have alu_src1  in  2  operand-A select: 00 forwarded rs1, 01 pc, 10 zero, 11 zero.
REQ-005 SHALL have alu_src2  in  2  operand-B select: 00 forwarded rs2, 01 imm, 10 constant 4, 11 zero.
REQ-006 SHALL have alu_op  in  3  RV32 funct3-style ALU op.
REQ-007 SHALL have alu_op_chosen  in  1  op modifier: SUB vs ADD, SRA vs SRL.
REQ-008 SHALL have mul_req  in  1  instruction is MUL (low 32 bits of the product).
REQ-009 SHALL have rs1, rs2  in  5 each  source register indices.
REQ-010 SHALL have rs1_data, rs2_data, pc, imm  in  32 each  operands from ID/EX.
REQ-011 SHALL have rd  in  5  destination index.
REQ-012 SHALL have mem_fwd_we, mem_fwd_rd, mem_fwd_data  in  1/5/32  EX/MEM forwarding source.
REQ-013 SHALL have wb_fwd_we, wb_fwd_rd, wb_fwd_data  in  1/5/32  MEM/WB forwarding source.
REQ-014 SHALL have ex_stall  out  1  hold request to the ID/EX register and earlier stages.
REQ-015 SHALL have ctrl_out  out  7  registered ctrl_in.
REQ-016 SHALL have alu_result_out, store_data_out  out  32 each  registered result and forwarded rs2.
REQ-017 SHALL have rd_out  out  5  registered rd.

Function
REQ-018 Forwarding SHALL be combinational per operand: MEM source when we=1, rd match, rd!=0; otherwise WB source under the same rule; otherwise register data. MEM SHALL win over WB.
REQ-019 ALU ops SHALL be: 000 ADD/SUB, 001 SLL, 010 SLT signed, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND. Shift amount = B[4:0]. Add/sub wraps modulo 2^32.
REQ-020 Non-MUL instructions SHALL have latency 1: outputs update on the next rising edge, and ex_stall SHALL be 0.
REQ-021 The MUL FSM SHALL have states IDLE, BUSY, DONE, plus a 5-bit iteration counter.
REQ-022 IDLE with mul_req=1 SHALL:
  - assert ex_stall combinationally;
  - latch the forwarded A and B;
  - clear the accumulator and counter;
  - go to BUSY.
REQ-023 BUSY SHALL perform one shift-add iteration per cycle, hold ex_stall=1, and go to DONE after the iteration with counter=31 (32 iterations).
REQ-024 DONE SHALL:
  - drive ex_stall=0;
  - load the product into alu_result_out on that edge, with ctrl_out, rd_out and store_data_out from the held inputs;
  - return to IDLE;
  - ignore mul_req in that cycle.
REQ-025 ex_stall SHALL be high for exactly 33 consecutive cycles per MUL.
REQ-026 While ex_stall=1, output registers SHALL load a bubble: ctrl_out=0, rd_out=0, data=0.
REQ-027 Latched MUL operands SHALL be immune to forwarding-source changes during BUSY.

Reset
REQ-028 While rst=0, all outputs SHALL be 0, FSM=IDLE, counter=0, accumulator=0, and ex_stall=0.
REQ-029 Reset asserted mid-MUL SHALL abort the operation with no result emitted, and after release the FSM SHALL sit in IDLE.

Configuration
REQ-030 Macro EX_STAGE_MUL_EN SHALL control the multiplier.
  - Defined: REQ-021..027 apply.
  - Undefined: no FSM or multiplier logic, mul_req ignored (the instruction executes as its alu_op), ex_stall tied to 0.

Verification
REQ-031 ADD: A=5, B=7, alu_op=000, chosen=0 -> alu_result_out=12 one edge later, ex_stall=0.
REQ-032 SUB/SRA: 3-5 -> 0xFFFFFFFE; SRA 0x80000000 by 4 -> 0xF8000000; SRL -> 0x08000000.
REQ-033 Forwarding: rs1=3; MEM rd=3 data 0x11; WB rd=3 data 0x22 -> A=0x11. With MEM we=0 -> 0x22. With rs1=0 and both sources at rd=0 -> rs1_data used.
REQ-034 MUL (EX_STAGE_MUL_EN): 0xFFFFFFFF*3 -> ex_stall high 33 cycles, bubbles meanwhile, then alu_result_out=0xFFFFFFFD. Forwarding data changed during BUSY SHALL not affect the result.
REQ-035 Reset mid-MUL: drop rst at counter=10 -> outputs 0 immediately. After release with mul_req=0, no product appears and ex_stall=0.
REQ-036 Without the macro: mul_req=1, alu_op=000, A=6, B=7 -> 13 in one cycle, ex_stall never 1.
